// File: rtl/fifo_pkg.sv
// Shared constants and elaboration-time helpers for the parametrised FIFO family.
package fifo_pkg;

   localparam int DEF_DATA_W    = 8;
   localparam int DEF_DEPTH     = 16;
   localparam int DEF_AE_THRESH = 2;
   localparam int DEF_FWFT      = 0;

   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

   function automatic bit is_pow2(input int value);
      return (value > 0) && ((value & (value - 1)) == 0);
   endfunction

   function automatic bit params_legal(input int data_w, input int depth,
                                       input int ae_thresh, input int af_thresh);
      return (data_w >= 1) && (depth >= 4) && is_pow2(depth) &&
             (ae_thresh >= 0) && (ae_thresh < af_thresh) && (af_thresh <= depth);
   endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one synchronous write port, one asynchronous read port.
module fifo_ram
   import fifo_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH
) (
   input  logic                      clk,
   input  logic                      wr_en,
   input  logic [clog2(DEPTH)-1:0]   wr_addr,
   input  logic [DATA_W-1:0]         wr_data,
   input  logic [clog2(DEPTH)-1:0]   rd_addr,
   output logic [DATA_W-1:0]         rd_data
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         r_mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = r_mem[rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with occupancy count, threshold flags, sticky error flags and optional FWFT read.
// Pointers carry one extra MSB so full and empty are distinguishable without a separate counter.
module sync_fifo_param
   import fifo_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = DEF_AE_THRESH,
   parameter int FWFT      = DEF_FWFT
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_en,
   input  logic [DATA_W-1:0]       data_in,
   input  logic                    rd_en,
   input  logic                    err_clr,
   output logic [DATA_W-1:0]       data_out,
   output logic                    full,
   output logic                    empty,
   output logic                    almost_full,
   output logic                    almost_empty,
   output logic [clog2(DEPTH):0]   count,
   output logic                    overflow,
   output logic                    underflow
);

   localparam int AW = clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [AW:0] AF_C    = (AW+1)'(AF_THRESH);
   localparam logic [AW:0] AE_C    = (AW+1)'(AE_THRESH);

   if (!params_legal(DATA_W, DEPTH, AE_THRESH, AF_THRESH)) begin : g_bad_params
      $error("sync_fifo_param: illegal DATA_W/DEPTH/AE_THRESH/AF_THRESH combination");
   end

   logic [AW:0]       r_wr_ptr;
   logic [AW:0]       r_rd_ptr;
   logic [AW:0]       w_count;
   logic              w_wr_acc;
   logic              w_rd_acc;
   logic [DATA_W-1:0] w_ram_rd;
   logic              r_overflow;
   logic              r_underflow;

   assign w_count      = r_wr_ptr - r_rd_ptr;
   assign count        = w_count;
   assign empty        = (w_count == '0);
   assign full         = (w_count == DEPTH_C);
   assign almost_full  = (w_count >= AF_C);
   assign almost_empty = (w_count <= AE_C);

   // A read on a full FIFO frees the slot, so the write rides along in the same cycle.
   assign w_rd_acc = rd_en && !empty;
   assign w_wr_acc = wr_en && (!full || rd_en);

   fifo_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk     (clk),
      .wr_en   (w_wr_acc),
      .wr_addr (r_wr_ptr[AW-1:0]),
      .wr_data (data_in),
      .rd_addr (r_rd_ptr[AW-1:0]),
      .rd_data (w_ram_rd)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // A new rejection in the same cycle as err_clr leaves the flag set.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (wr_en && !w_wr_acc) r_overflow <= 1'b1;
         else if (err_clr)       r_overflow <= 1'b0;
         if (rd_en && !w_rd_acc) r_underflow <= 1'b1;
         else if (err_clr)       r_underflow <= 1'b0;
      end
   end

   assign overflow  = r_overflow;
   assign underflow = r_underflow;

   if (FWFT != 0) begin : g_fwft
      // Head word is only meaningful while non-empty; forcing zero otherwise keeps reset state clean.
      assign data_out = empty ? '0 : w_ram_rd;
   end else begin : g_std
      logic [DATA_W-1:0] r_dout;
      always_ff @(posedge clk) begin
         if (rst)           r_dout <= '0;
         else if (w_rd_acc) r_dout <= w_ram_rd;
      end
      assign data_out = r_dout;
   end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param: a standard-read and an FWFT instance share one stimulus stream.
module tb_sync_fifo_param;

   logic       clk = 1'b0;
   logic       rst, wr_en, rd_en, err_clr;
   logic [7:0] data_in;

   logic [7:0] d0_data_out, d1_data_out;
   logic       d0_full, d0_empty, d0_af, d0_ae, d0_ovf, d0_unf;
   logic       d1_full, d1_empty, d1_af, d1_ae, d1_ovf, d1_unf;
   logic [4:0] d0_count, d1_count;

   int         n_checks = 0;
   int         n_errors = 0;
   logic [7:0] sb_q[$];
   int         m_cnt = 0;
   logic [7:0] exp_dout = 8'h00;

   always #5 clk = ~clk;

   sync_fifo_param #(.DATA_W(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)) dut0 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en), .err_clr(err_clr),
      .data_out(d0_data_out), .full(d0_full), .empty(d0_empty), .almost_full(d0_af),
      .almost_empty(d0_ae), .count(d0_count), .overflow(d0_ovf), .underflow(d0_unf));

   sync_fifo_param #(.DATA_W(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1)) dut1 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en), .err_clr(err_clr),
      .data_out(d1_data_out), .full(d1_full), .empty(d1_empty), .almost_full(d1_af),
      .almost_empty(d1_ae), .count(d1_count), .overflow(d1_ovf), .underflow(d1_unf));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      sb_q.delete();
      m_cnt    = 0;
      exp_dout = 8'h00;
   endtask

   // Drive one cycle and advance the reference model; returns the word a standard read should show.
   task automatic cycle(input logic w, input logic r, input logic [7:0] d, input logic clr,
                        output logic rd_ok, output logic [7:0] rd_val);
      logic wa, ra;
      wr_en = w; rd_en = r; data_in = d; err_clr = clr;
      ra = r && (m_cnt > 0);
      wa = w && ((m_cnt < 16) || r);
      tick();
      rd_ok  = ra;
      rd_val = exp_dout;
      if (ra) begin
         rd_val   = sb_q.pop_front();
         exp_dout = rd_val;
         m_cnt--;
      end
      if (wa) begin
         sb_q.push_back(d);
         m_cnt++;
      end
      wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; data_in = 8'h00;
      tick();
      rst = 1'b0;
      model_reset();
      n_checks++; if (d0_count !== 5'd0) begin n_errors++; $display("FAIL reset_count got=%0d exp=0", d0_count); end
      n_checks++; if (d0_empty !== 1'b1) begin n_errors++; $display("FAIL reset_empty got=%b exp=1", d0_empty); end
      n_checks++; if (d0_ae !== 1'b1) begin n_errors++; $display("FAIL reset_almost_empty got=%b exp=1", d0_ae); end
      n_checks++; if (d0_full !== 1'b0 || d0_af !== 1'b0) begin n_errors++; $display("FAIL reset_full_af got=%b%b exp=00", d0_full, d0_af); end
      n_checks++; if (d0_ovf !== 1'b0 || d0_unf !== 1'b0) begin n_errors++; $display("FAIL reset_errflags got=%b%b exp=00", d0_ovf, d0_unf); end
      n_checks++; if (d0_data_out !== 8'h00) begin n_errors++; $display("FAIL reset_dout got=%h exp=00", d0_data_out); end
      n_checks++; if (d1_data_out !== 8'h00 || d1_empty !== 1'b1) begin n_errors++; $display("FAIL reset_fwft got=%h/%b exp=00/1", d1_data_out, d1_empty); end
   endtask

   task automatic test_fill_drain();
      logic ok; logic [7:0] v;
      for (int i = 1; i <= 16; i++) begin
         cycle(1'b1, 1'b0, 8'(i), 1'b0, ok, v);
         n_checks++; if (d0_count !== 5'(i)) begin n_errors++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, d0_count, i); end
         n_checks++; if (d0_ae !== (i <= 2)) begin n_errors++; $display("FAIL fill_almost_empty[%0d] got=%b exp=%b", i, d0_ae, (i <= 2)); end
         n_checks++; if (d0_af !== (i >= 14)) begin n_errors++; $display("FAIL fill_almost_full[%0d] got=%b exp=%b", i, d0_af, (i >= 14)); end
      end
      n_checks++; if (d0_full !== 1'b1) begin n_errors++; $display("FAIL fill_full got=%b exp=1", d0_full); end
      for (int i = 1; i <= 16; i++) begin
         cycle(1'b0, 1'b1, 8'h00, 1'b0, ok, v);
         n_checks++; if (!ok || d0_data_out !== v || v !== 8'(i)) begin n_errors++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, d0_data_out, 8'(i)); end
      end
      n_checks++; if (d0_empty !== 1'b1 || d0_count !== 5'd0) begin n_errors++; $display("FAIL drain_empty got=%b/%0d exp=1/0", d0_empty, d0_count); end
   endtask

   task automatic test_overflow();
      logic ok; logic [7:0] v;
      for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 8'(8'h20 + i), 1'b0, ok, v);
      cycle(1'b1, 1'b0, 8'hAA, 1'b0, ok, v);
      n_checks++; if (d0_ovf !== 1'b1) begin n_errors++; $display("FAIL ovf_set got=%b exp=1", d0_ovf); end
      n_checks++; if (d0_count !== 5'd16) begin n_errors++; $display("FAIL ovf_count got=%0d exp=16", d0_count); end
      for (int i = 0; i < 16; i++) begin
         cycle(1'b0, 1'b1, 8'h00, 1'b0, ok, v);
         n_checks++; if (!ok || d0_data_out !== v || d0_data_out === 8'hAA) begin n_errors++; $display("FAIL ovf_drain[%0d] got=%h exp=%h", i, d0_data_out, v); end
      end
      cycle(1'b0, 1'b0, 8'h00, 1'b1, ok, v);
      n_checks++; if (d0_ovf !== 1'b0) begin n_errors++; $display("FAIL ovf_clear got=%b exp=0", d0_ovf); end
   endtask

   task automatic test_underflow();
      logic ok; logic [7:0] v; logic [7:0] held;
      held = exp_dout;
      cycle(1'b0, 1'b1, 8'h00, 1'b0, ok, v);
      n_checks++; if (d0_unf !== 1'b1) begin n_errors++; $display("FAIL unf_set got=%b exp=1", d0_unf); end
      n_checks++; if (d0_data_out !== held) begin n_errors++; $display("FAIL unf_dout_hold got=%h exp=%h", d0_data_out, held); end
      cycle(1'b1, 1'b1, 8'h55, 1'b0, ok, v);
      n_checks++; if (d0_count !== 5'd1 || d0_unf !== 1'b1) begin n_errors++; $display("FAIL empty_wr_rd got=%0d/%b exp=1/1", d0_count, d0_unf); end
      cycle(1'b0, 1'b1, 8'h00, 1'b0, ok, v);
      n_checks++; if (!ok || d0_data_out !== 8'h55 || v !== 8'h55) begin n_errors++; $display("FAIL empty_wr_rd_data got=%h exp=55", d0_data_out); end
      cycle(1'b0, 1'b1, 8'h00, 1'b1, ok, v);
      n_checks++; if (d0_unf !== 1'b1) begin n_errors++; $display("FAIL unf_set_wins got=%b exp=1", d0_unf); end
      cycle(1'b0, 1'b0, 8'h00, 1'b1, ok, v);
      n_checks++; if (d0_unf !== 1'b0) begin n_errors++; $display("FAIL unf_clear got=%b exp=0", d0_unf); end
   endtask

   task automatic test_back_to_back();
      logic ok; logic [7:0] v;
      for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 8'($urandom_range(0, 255)), 1'b0, ok, v);
      for (int i = 0; i < 20; i++) begin
         cycle(1'b1, 1'b1, 8'($urandom_range(0, 255)), 1'b0, ok, v);
         n_checks++; if (!ok || d0_data_out !== v) begin n_errors++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, d0_data_out, v); end
         n_checks++; if (d0_count !== 5'd16 || d0_full !== 1'b1 || d0_ovf !== 1'b0) begin n_errors++; $display("FAIL b2b_state[%0d] got=%0d/%b/%b exp=16/1/0", i, d0_count, d0_full, d0_ovf); end
      end
      for (int i = 0; i < 16; i++) begin
         cycle(1'b0, 1'b1, 8'h00, 1'b0, ok, v);
         n_checks++; if (!ok || d0_data_out !== v) begin n_errors++; $display("FAIL b2b_drain[%0d] got=%h exp=%h", i, d0_data_out, v); end
      end
   endtask

   task automatic test_fwft();
      logic ok; logic [7:0] v;
      rst = 1'b1; tick(); rst = 1'b0; model_reset();
      cycle(1'b1, 1'b0, 8'h3C, 1'b0, ok, v);
      n_checks++; if (d1_data_out !== 8'h3C || d1_empty !== 1'b0) begin n_errors++; $display("FAIL fwft_visible got=%h/%b exp=3c/0", d1_data_out, d1_empty); end
      n_checks++; if (d0_data_out !== 8'h00) begin n_errors++; $display("FAIL std_no_early_data got=%h exp=00", d0_data_out); end
      cycle(1'b0, 1'b1, 8'h00, 1'b0, ok, v);
      n_checks++; if (d1_empty !== 1'b1 || d0_data_out !== 8'h3C) begin n_errors++; $display("FAIL fwft_consume got=%b/%h exp=1/3c", d1_empty, d0_data_out); end
   endtask

   task automatic test_reset_mid_burst();
      logic ok; logic [7:0] v;
      for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 8'(8'h40 + i), 1'b0, ok, v);
      cycle(1'b1, 1'b1, 8'h00, 1'b0, ok, v);
      rst = 1'b1; wr_en = 1'b1; rd_en = 1'b1; data_in = 8'h77;
      tick();
      rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
      model_reset();
      n_checks++; if (d0_count !== 5'd0 || d0_empty !== 1'b1 || d0_ae !== 1'b1) begin n_errors++; $display("FAIL midrst_occupancy got=%0d/%b/%b exp=0/1/1", d0_count, d0_empty, d0_ae); end
      n_checks++; if (d0_full !== 1'b0 || d0_af !== 1'b0 || d0_ovf !== 1'b0 || d0_unf !== 1'b0) begin n_errors++; $display("FAIL midrst_flags got=%b%b%b%b exp=0000", d0_full, d0_af, d0_ovf, d0_unf); end
      n_checks++; if (d0_data_out !== 8'h00 || d1_data_out !== 8'h00) begin n_errors++; $display("FAIL midrst_dout got=%h/%h exp=00/00", d0_data_out, d1_data_out); end
      cycle(1'b1, 1'b0, 8'h99, 1'b0, ok, v);
      cycle(1'b0, 1'b1, 8'h00, 1'b0, ok, v);
      n_checks++; if (!ok || d0_data_out !== 8'h99) begin n_errors++; $display("FAIL midrst_first_word got=%h exp=99", d0_data_out); end
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_overflow();
      test_underflow();
      test_back_to_back();
      test_fwft();
      test_reset_mid_burst();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
